// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed 5-tap FIR: tap count,
// tap-index width and the scheduler state encoding.
package fir_pkg;

  localparam int NTAPS = 5;
  localparam int TAP_W = 3;
  localparam logic [TAP_W-1:0] LAST_TAP = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fir_tap_mac.sv
// Single signed multiply-accumulate unit shared by all taps; the product is
// sign-extended to the accumulator width so the five-term sum cannot wrap.
module fir_tap_mac #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = DW + CW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  input  logic                 clear,
  input  logic                 en,
  output logic signed [OW-1:0] acc
);

  logic signed [DW+CW-1:0] prod_s;
  logic signed [OW-1:0]    prod_ext_s;
  logic signed [OW-1:0]    acc_r;

  assign prod_s     = (DW+CW)'(sample) * (DW+CW)'(coef);
  assign prod_ext_s = {{(OW-DW-CW){prod_s[DW+CW-1]}}, prod_s};
  assign acc        = acc_r;

  // Accumulator: clear wins over enable so a new sample always starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {OW{1'b0}};
    end else if (clear) begin
      acc_r <= {OW{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + prod_ext_s;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// 5-tap direct-form FIR computed one tap per cycle on a shared MAC, with a
// valid/ready sample input, valid/ready result output and a coefficient port.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = DW + CW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_rej,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_y,
  output logic                 busy
);

  state_e               state_r, state_nxt_s;
  logic signed [DW-1:0] x_r [NTAPS];
  logic signed [CW-1:0] h_r [NTAPS];
  logic [TAP_W-1:0]     tap_r;
  logic signed [OW-1:0] acc_s;
  logic signed [OW-1:0] y_hold_r;
  logic                 coef_rej_r;
  logic                 in_hs_s;
  logic                 out_hs_s;
  logic                 mac_en_s;
  logic                 coef_ok_s;

  assign in_hs_s   = in_valid && (state_r == ST_IDLE);
  assign out_hs_s  = out_ready && (state_r == ST_OUT);
  assign mac_en_s  = (state_r == ST_MAC);
  assign coef_ok_s = (state_r == ST_IDLE) && (coef_addr <= LAST_TAP);

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_OUT);
  assign busy      = (state_r != ST_IDLE);
  assign coef_rej  = coef_rej_r;
  // While presenting, the accumulator is frozen; afterwards the held copy is shown
  assign out_y     = (state_r == ST_OUT) ? acc_s : y_hold_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_MAC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_MAC: begin
        if (tap_r == LAST_TAP) state_nxt_s = ST_OUT;
        else                   state_nxt_s = ST_MAC;
      end
      ST_OUT: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sample history shift on each accepted input
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) x_r[k] <= {DW{1'b0}};
    end else if (in_hs_s) begin
      x_r[0] <= in_x;
      for (int k = 1; k < NTAPS; k++) x_r[k] <= x_r[k-1];
    end
  end

  // Coefficient bank: writes land only while idle and in range
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) h_r[k] <= {CW{1'b0}};
    end else if (coef_we && coef_ok_s) begin
      h_r[coef_addr] <= coef_data;
    end
  end

  // Rejection pulse, one cycle after a dropped write
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_rej_r <= 1'b0;
    end else begin
      coef_rej_r <= coef_we && !coef_ok_s;
    end
  end

  // Tap index walks 0..4 through the MAC phase
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_r <= {TAP_W{1'b0}};
    end else if (in_hs_s) begin
      tap_r <= {TAP_W{1'b0}};
    end else if (mac_en_s) begin
      tap_r <= tap_r + 3'd1;
    end
  end

  // Result copy kept after the output handshake until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      y_hold_r <= {OW{1'b0}};
    end else if (out_hs_s) begin
      y_hold_r <= acc_s;
    end
  end

  fir_tap_mac #(
    .DW(DW),
    .CW(CW),
    .OW(OW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .sample(x_r[tap_r]),
    .coef  (h_r[tap_r]),
    .clear (in_hs_s),
    .en    (mac_en_s),
    .acc   (acc_s)
  );

endmodule
